esp_at_seq: RTL and testbench
=============================

# esp_at_seq

AT-command sequencer for the PMOD ESP32 link. It sits between system control logic and the `UART_COM` byte streams, and sends one AT command selected from an internal command table, followed by CR LF. It then scans the received byte stream for the final result line, `OK\r\n` or `ERROR\r\n`, or gives up after a timeout. It reports a single result per command, so higher-level logic can bring up the ESP32 one command at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100_000_000: response timeout in `clk` cycles (1 s at 100 MHz); must be ≥ 2.
- `CMD_W`, default 2: width of the command index; the table holds 2^CMD_W entries.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request; sampled only in IDLE
- `cmd_id`  in  CMD_W  command table index, captured with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the result is valid
- `ok`  out  1  last command ended with `OK\r\n`; held until next accepted `start`
- `err`  out  1  last command ended with `ERROR\r\n`; held until next accepted `start`
- `tout`  out  1  last command timed out; held until next accepted `start`
- `tx_data`  out  8  byte to UART_COM transmitter
- `tx_valid`  out  1  tx handshake valid
- `tx_ready`  in  1  tx handshake ready
- `rx_data`  in  8  byte from UART_COM receiver
- `rx_valid`  in  1  rx handshake valid
- `rx_ready`  out  1  rx handshake ready; constant 1 while out of reset

## Operation
- States: IDLE, SEND, SEND_CR, SEND_LF, WAIT, DONE.
- **IDLE**
  - On `start`=1: latch `cmd_id`, clear `ok`/`err`/`tout`, clear byte index, go to SEND.
- **SEND**
  - `tx_data` = table[cmd][idx] and `tx_valid`=1.
  - On `tx_valid && tx_ready`: idx+1.
  - After the last byte (idx = len-1) is accepted, go to SEND_CR.
- **SEND_CR / SEND_LF**
  - Drive 0x0D, then 0x0A, each held until accepted.
  - After LF is accepted, go to WAIT. Entry to WAIT clears the match shift register and the timeout counter.
- **WAIT**
  - Every accepted rx byte shifts into a 7-byte history register.
  - If the last 4 bytes equal "OK\r\n", set `ok` and go to DONE.
  - If the last 7 bytes equal "ERROR\r\n", set `err` and go to DONE.
  - The ESP echo line (command + CR LF) never matches and is discarded.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- Rx bytes accepted outside WAIT are dropped.
- `tx_data` and `tx_valid` stay stable while `tx_valid && !tx_ready`. `tx_valid` is 0 in IDLE, WAIT and DONE.
- `start` while `busy`: ignored.
- Simultaneous OK/ERROR match and timeout expiry in the same cycle: the match wins and `tout` stays 0.
- A `start` in the DONE cycle is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `ok`, `err`, `tout`, `tx_valid` = 0; `tx_data` = 0x00; `rx_ready` = 1.
- Reset mid-operation forces all of the above immediately (asynchronously). Any partially sent command is abandoned.
- `start` accepted at cycle 0 → `busy`=1 and first `tx_valid`=1 at cycle 1.
- With `tx_ready` held at 1, a command of length L occupies cycles 1..L+2 and WAIT begins at cycle L+3.
- Result latency: `ok`/`err` and `done` assert the cycle after the rx handshake carrying the final `\n`.
- Timeout: counter increments every WAIT cycle; at count TIMEOUT_CYCLES-1, set `tout` and go to DONE.

## Configuration
- `ESP_AT_TIMEOUT_EN` defined: timeout counter is compiled in, sized $clog2(TIMEOUT_CYCLES) bits, and behaves as above.
- Undefined: no counter; WAIT exits only on a match, and `tout` is tied to 0. Recovery from a silent module is by reset only.

## Structure
- Shared package `esp_at_pkg`:
  - state encoding;
  - ASCII constants (CR, LF, "OK\r\n", "ERROR\r\n");
  - command table with max length 16 bytes: 0 "AT", 1 "AT+RST", 2 "AT+CWMODE=1", 3 "AT+CIPMUX=0";
  - per-entry length constants.
- One sub-module, `esp_at_resp_match`:
  - 7-byte history shift register with clear, plus both comparators;
  - outputs `hit_ok` and `hit_err` combinationally from the registered history.

## Test plan
- `cmd_id`=0, `tx_ready`=1, rx returns "AT\r\n\r\nOK\r\n" → tx bytes 41 54 0D 0A on cycles 1–4; `done` with `ok`=1, `err`=0, `tout`=0.
- `cmd_id`=2, `tx_ready` toggling every other cycle → "AT+CWMODE=1\r\n" sent in order with no byte duplicated or dropped, and `tx_data` stable while stalled.
- `cmd_id`=1, rx returns "ERROR\r\n" → `done` with `err`=1, `ok`=0.
- `ESP_AT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50, no rx after send → `tout`=1 and `done` exactly 50 cycles after WAIT entry.
- `start` pulsed during SEND, plus rx "OK\r\n" injected during SEND → the start is ignored and the premature OK does not complete the command; a later real OK does.
- `rst` asserted mid-SEND → `tx_valid`=0 and `busy`=0 immediately; the next `start` after release transmits from byte 0.

Source files
------------

// File: rtl/esp_at_pkg.sv
// Shared types and constants for the ESP32 AT-command sequencer:
// FSM encoding, ASCII result patterns and the fixed command table.
package esp_at_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_SEND_CR,
    S_SEND_LF,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int unsigned CMD_MAX  = 16;
  localparam int unsigned CMD_BITS = 8 * CMD_MAX;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LEN_W    = 5;
  localparam int unsigned HIST_W   = 56;

  localparam logic [7:0]  ASCII_CR = 8'h0D;
  localparam logic [7:0]  ASCII_LF = 8'h0A;
  localparam logic [31:0] RESP_OK  = {"OK", ASCII_CR, ASCII_LF};
  localparam logic [55:0] RESP_ERR = {"ERROR", ASCII_CR, ASCII_LF};

  // Command strings are right-justified; byte 0 is the most significant used byte.
  localparam logic [CMD_BITS-1:0] CMD_AT     = CMD_BITS'("AT");
  localparam logic [CMD_BITS-1:0] CMD_RST    = CMD_BITS'("AT+RST");
  localparam logic [CMD_BITS-1:0] CMD_CWMODE = CMD_BITS'("AT+CWMODE=1");
  localparam logic [CMD_BITS-1:0] CMD_CIPMUX = CMD_BITS'("AT+CIPMUX=0");

  localparam logic [LEN_W-1:0] LEN_AT     = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_RST    = LEN_W'(6);
  localparam logic [LEN_W-1:0] LEN_CWMODE = LEN_W'(11);
  localparam logic [LEN_W-1:0] LEN_CIPMUX = LEN_W'(11);

  function automatic logic [LEN_W-1:0] cmd_len(input logic [7:0] id);
    case (id)
      8'd1:    return LEN_RST;
      8'd2:    return LEN_CWMODE;
      8'd3:    return LEN_CIPMUX;
      default: return LEN_AT;
    endcase
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [7:0] id, input logic [IDX_W-1:0] idx);
    logic [CMD_BITS-1:0] s;
    logic [LEN_W-1:0]    pos;
    case (id)
      8'd1:    s = CMD_RST;
      8'd2:    s = CMD_CWMODE;
      8'd3:    s = CMD_CIPMUX;
      default: s = CMD_AT;
    endcase
    pos = cmd_len(id) - LEN_W'(1) - {1'b0, idx};
    s   = s >> {pos, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/esp_at_resp_match.sv
// Seven-byte receive history with clear, plus the OK / ERROR line comparators.
// Comparators look at the history including the byte accepted this cycle.
module esp_at_resp_match
  import esp_at_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift,
  input  logic [7:0] data,
  output logic       hit_ok,
  output logic       hit_err
);

  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_next;

  always_comb begin
    hist_next = hist;
    if (shift) hist_next = {hist[HIST_W-9:0], data};
  end

  assign hit_ok  = (hist_next[31:0] == RESP_OK);
  assign hit_err = (hist_next == RESP_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       hist <= '0;
    else if (clr)   hist <= '0;
    else if (shift) hist <= hist_next;
  end

endmodule

// File: rtl/esp_at_seq.sv
// AT-command sequencer: sends a table command plus CR LF, then waits for OK/ERROR.
// Define ESP_AT_TIMEOUT_EN to compile in the response timeout counter.
module esp_at_seq
  import esp_at_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned CMD_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CMD_W-1:0] cmd_id,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic             err,
  output logic             tout,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("esp_at_seq: TIMEOUT_CYCLES must be at least 2");
  end

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [CMD_W-1:0]   cmd, cmd_d;
  logic               busy_d, done_d, ok_d, err_d, tout_d, tx_valid_d;
  logic [7:0]         tx_data_d;
  logic               wait_clr;
  logic               rx_shift;
  logic               hit_ok, hit_err;
  logic               timeout_hit;

  // The receiver is never back-pressured; bytes outside WAIT are simply dropped.
  assign rx_ready = 1'b1;
  assign rx_shift = (state == S_WAIT) && rx_valid;

  esp_at_resp_match u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .shift   (rx_shift),
    .data    (rx_data),
    .hit_ok  (hit_ok),
    .hit_err (hit_err)
  );

`ifdef ESP_AT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (wait_clr)        cnt <= '0;
    else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cmd_d      = cmd;
    ok_d       = ok;
    err_d      = err;
    tout_d     = tout;
    done_d     = 1'b0;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    wait_clr   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          cmd_d      = cmd_id;
          ok_d       = 1'b0;
          err_d      = 1'b0;
          tout_d     = 1'b0;
          idx_d      = '0;
          state_d    = S_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_byte(8'(cmd_id), IDX_W'(0));
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if ({1'b0, idx} == cmd_len(8'(cmd)) - LEN_W'(1)) begin
            state_d   = S_SEND_CR;
            tx_data_d = ASCII_CR;
          end else begin
            idx_d     = idx + IDX_W'(1);
            tx_data_d = cmd_byte(8'(cmd), idx + IDX_W'(1));
          end
        end
      end
      S_SEND_CR: begin
        if (tx_ready) begin
          state_d   = S_SEND_LF;
          tx_data_d = ASCII_LF;
        end
      end
      S_SEND_LF: begin
        if (tx_ready) begin
          state_d    = S_WAIT;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          wait_clr   = 1'b1;
        end
      end
      S_WAIT: begin
        // A result line completing on the expiry cycle takes priority over timeout
        if (hit_ok) begin
          ok_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (hit_err) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          tout_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cmd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err      <= 1'b0;
      tout     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      cmd      <= cmd_d;
      busy     <= busy_d;
      done     <= done_d;
      ok       <= ok_d;
      err      <= err_d;
      tout     <= tout_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_esp_at_seq.sv
// Self-checking bench for esp_at_seq: directed scenarios plus randomized commands
// and handshakes, checked against a string/queue model of the command protocol.
module tb_esp_at_seq;

  localparam int unsigned TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd_id = 2'd0;
  logic       busy, done, ok, err, tout, tx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  esp_at_seq #(.TIMEOUT_CYCLES(TO), .CMD_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_id(cmd_id),
    .busy(busy), .done(done), .ok(ok), .err(err), .tout(tout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  string      cmds[4];
  logic [7:0] ok_pat[4]  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
  logic [7:0] err_pat[7] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
  logic [7:0] rxq[$];
  logic [7:0] hist[$];

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1 = history ends in OK CR LF, 2 = ends in ERROR CR LF, 0 = neither
  function automatic int resp_kind();
    int n = hist.size();
    bit m;
    if (n >= 4) begin
      m = 1'b1;
      for (int i = 0; i < 4; i++) if (hist[n-4+i] !== ok_pat[i]) m = 1'b0;
      if (m) return 1;
    end
    if (n >= 7) begin
      m = 1'b1;
      for (int i = 0; i < 7; i++) if (hist[n-7+i] !== err_pat[i]) m = 1'b0;
      if (m) return 2;
    end
    return 0;
  endfunction

  function automatic void add_str(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endfunction

  function automatic void add_crlf();
    rxq.push_back(8'h0D);
    rxq.push_back(8'h0A);
  endfunction

  // mode 0: tx_ready always 1, 1: toggling, 2: random. inject: rx OK + start during SEND.
  task automatic send_cmd(input int id, input int mode, input bit inject);
    logic [7:0] exp[$];
    logic [7:0] got[$];
    logic [7:0] prev;
    bit         stalled;
    int         cyc;
    for (int i = 0; i < cmds[id].len(); i++) exp.push_back(cmds[id][i]);
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
    stalled = 1'b0;
    prev    = 8'h00;
    @(negedge clk);
    start  = 1'b1;
    cmd_id = 2'(id);
    cyc    = 0;
    while (got.size() < exp.size() && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      rx_valid = 1'b0;
      chkb("send_busy", busy, 1'b1);
      chkb("send_valid", tx_valid, 1'b1);
      chkb("send_done", done, 1'b0);
      if (cyc == 1) begin
        chkb("start_clr_ok", ok, 1'b0);
        chkb("start_clr_err", err, 1'b0);
        chkb("start_clr_tout", tout, 1'b0);
      end
      if (stalled) chkv("tx_hold", 32'(tx_data), 32'(prev));
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2) == 1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject) begin
        if (cyc >= 1 && cyc <= 4) begin
          rx_valid = 1'b1;
          rx_data  = ok_pat[cyc-1];
        end
        if (cyc == 2) begin
          start  = 1'b1;
          cmd_id = 2'((id + 1) % 4);
        end
      end
      if (tx_valid && tx_ready) begin
        if (mode == 0) chkv("tx_cycle", 32'(cyc), 32'(got.size() + 1));
        chkv("tx_byte", 32'(tx_data), 32'(exp[got.size()]));
        got.push_back(tx_data);
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        prev    = tx_data;
      end
    end
    chkv("tx_count", 32'(got.size()), 32'(exp.size()));
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'($urandom_range(0, 1));
    chkb("wait_valid", tx_valid, 1'b0);
    chkb("wait_busy", busy, 1'b1);
    chkb("wait_done0", done, 1'b0);
  endtask

  // Feed rxq during WAIT with random idle gaps until the model sees a result line.
  task automatic respond();
    int         kind;
    logic [7:0] b;
    hist.delete();
    kind = 0;
    while (rxq.size() > 0 && kind == 0) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        chkb("wait_done", done, 1'b0);
        chkb("wait_busy", busy, 1'b1);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      chkb("wait_done", done, 1'b0);
      b        = rxq.pop_front();
      rx_valid = 1'b1;
      rx_data  = b;
      hist.push_back(b);
      kind = resp_kind();
    end
    rxq.delete();
    @(negedge clk);
    rx_valid = 1'b0;
    chkb("done_pulse", done, 1'b1);
    chkb("res_ok", ok, kind == 1);
    chkb("res_err", err, kind == 2);
    chkb("res_tout", tout, 1'b0);
    chkb("done_busy", busy, 1'b1);
    start  = 1'b1;
    cmd_id = 2'($urandom_range(0, 3));
    @(negedge clk);
    start = 1'b0;
    chkb("idle_busy", busy, 1'b0);
    chkb("idle_done", done, 1'b0);
    chkb("hold_ok", ok, kind == 1);
    chkb("hold_err", err, kind == 2);
    chkb("idle_valid", tx_valid, 1'b0);
  endtask

  initial begin
    int id;
    cmds[0] = "AT";
    cmds[1] = "AT+RST";
    cmds[2] = "AT+CWMODE=1";
    cmds[3] = "AT+CIPMUX=0";

    // Reset values
    #3;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_ok", ok, 1'b0);
    chkb("rst_err", err, 1'b0);
    chkb("rst_tout", tout, 1'b0);
    chkb("rst_valid", tx_valid, 1'b0);
    chkv("rst_data", 32'(tx_data), 32'h0);
    chkb("rst_rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // AT with tx_ready held, echo then OK
    send_cmd(0, 0, 1'b0);
    add_str("AT"); add_crlf(); add_crlf(); add_str("OK"); add_crlf();
    respond();

    // AT+CWMODE=1 with tx_ready toggling
    send_cmd(2, 1, 1'b0);
    add_str(cmds[2]); add_crlf(); add_str("OK"); add_crlf();
    respond();

    // AT+RST answered with ERROR
    send_cmd(1, 2, 1'b0);
    add_str(cmds[1]); add_crlf(); add_str("ERROR"); add_crlf();
    respond();

    // Premature OK and a second start during SEND must both be ignored
    send_cmd(3, 0, 1'b1);
    add_str(cmds[3]); add_crlf(); add_str("OK"); add_crlf();
    respond();

`ifdef ESP_AT_TIMEOUT_EN
    // Silent module: done/tout exactly TO cycles after WAIT entry
    send_cmd(0, 0, 1'b0);
    for (int j = 1; j < TO; j++) begin
      @(negedge clk);
      chkb("to_early", done, 1'b0);
    end
    @(negedge clk);
    chkb("to_done", done, 1'b1);
    chkb("to_tout", tout, 1'b1);
    chkb("to_ok", ok, 1'b0);
    chkb("to_err", err, 1'b0);
    @(negedge clk);
    chkb("to_idle", busy, 1'b0);
    chkb("to_hold", tout, 1'b1);
`else
    // Silent module without timeout: stays in WAIT until reset
    send_cmd(0, 0, 1'b0);
    for (int j = 0; j < 2 * TO; j++) begin
      @(negedge clk);
      chkb("nto_done", done, 1'b0);
      chkb("nto_busy", busy, 1'b1);
      chkb("nto_tout", tout, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    // Reset mid-SEND, then a fresh command starts from byte 0
    @(negedge clk);
    start    = 1'b1;
    cmd_id   = 2'd2;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chkb("arst_valid", tx_valid, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chkv("arst_data", 32'(tx_data), 32'h0);
    chkb("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    send_cmd(2, 2, 1'b0);
    add_str(cmds[2]); add_crlf(); add_str("OK"); add_crlf();
    respond();

    // Randomized commands, handshakes and results
    repeat (6) begin
      id = int'($urandom_range(0, 3));
      send_cmd(id, int'($urandom_range(0, 2)), 1'b0);
      add_str(cmds[id]); add_crlf();
      if ($urandom_range(0, 1) == 1) add_crlf();
      if ($urandom_range(0, 1) == 1) add_str("OK");
      else add_str("ERROR");
      add_crlf();
      respond();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
